// File: rtl/regfile_mp.sv
// Multi-port integer register file: two prioritised write ports, NRP registered read
// ports with optional write-first bypass, hardwired-zero r0 and a busy scoreboard.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  output logic [NREG-1:0]     busy_vec,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  generate
    if (NREG != (1 << AW) || NRP < 1 || NRP > 4) begin : g_bad_param
      $error("regfile_mp: NREG must equal 2**AW and NRP must be in 1..4");
    end
  endgenerate

  logic [XLEN-1:0] r_mem      [NREG];
  logic [XLEN-1:0] w_mem_next [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic [XLEN-1:0] r_rd_data  [NRP];
  logic [XLEN-1:0] w_rd_val   [NRP];

  // Per-register next state: port 1 beats port 0, and a new busy_set beats a completing write.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign w_mem_next[gi]  = '0;
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_live
        logic w_hit0, w_hit1, w_set;
        assign w_hit0 = we0 && (waddr0 == AW'(gi));
        assign w_hit1 = we1 && (waddr1 == AW'(gi));
        assign w_set  = busy_set && (busy_addr == AW'(gi));
        assign w_mem_next[gi]  = w_hit1 ? wdata1 : (w_hit0 ? wdata0 : r_mem[gi]);
        assign w_busy_next[gi] = w_set ? 1'b1 : ((w_hit0 || w_hit1) ? 1'b0 : r_busy[gi]);
      end
    end

    for (gi = 0; gi < NRP; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rd_addr[gi*AW +: AW];
      always_comb begin
        w_rd_val[gi] = (BYPASS != 0) ? w_mem_next[w_addr] : r_mem[w_addr];
        if (ZERO_REG != 0 && w_addr == '0) w_rd_val[gi] = '0;
      end
      assign rd_data[gi*XLEN +: XLEN] = r_rd_data[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      for (int k = 0; k < NRP; k++) r_rd_data[k] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= w_mem_next[i];
      for (int k = 0; k < NRP; k++) r_rd_data[k] <= w_rd_val[k];
      r_busy <= w_busy_next;
    end
  end

  assign busy_vec = r_busy;
  assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (bypass, zero r0) and a
// read-old, no-zero-register instance driven by the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic        we0, we1, busy_set;
  logic [4:0]  waddr0, waddr1, busy_addr, dbg_addr;
  logic [31:0] wdata0, wdata1;
  logic [31:0] busy_vec_a, busy_vec_b;
  logic [31:0] dbg_data_a, dbg_data_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(busy_vec_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_a)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(busy_vec_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; busy_set = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; busy_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic peek(input logic [4:0] a);
    dbg_addr = a;
    #1;
  endtask

  initial begin
    reset = 1'b1; idle(); set_rd(5'd0, 5'd0); dbg_addr = '0;
    step();
    step();
    reset = 1'b0;

    // Post-reset: every register reads 0 on both ports, no busy bits.
    for (int k = 0; k < 32; k++) begin
      set_rd(5'(k), 5'(31 - k));
      step();
      chk($sformatf("rst_rd0_r%0d", k), rd_data_a[31:0], 32'h0);
      chk($sformatf("rst_rd1_r%0d", 31 - k), rd_data_a[63:32], 32'h0);
    end
    chk("rst_busy_a", busy_vec_a, 32'h0);
    chk("rst_busy_b", busy_vec_b, 32'h0);

    // Single write with same-cycle read of that address.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_rd(5'd5, 5'd5);
    step();
    idle();
    chk("byp_rd0_r5", rd_data_a[31:0], 32'hDEADBEEF);
    chk("old_rd0_r5", rd_data_b[31:0], 32'h0);
    step();
    chk("old_rd0_r5_later", rd_data_b[31:0], 32'hDEADBEEF);

    // Both ports to the same address: port 1 wins.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222; set_rd(5'd7, 5'd5);
    step();
    idle();
    peek(5'd7);
    chk("prio_dbg_a_r7", dbg_data_a, 32'h2222);
    chk("prio_dbg_b_r7", dbg_data_b, 32'h2222);
    chk("prio_byp_rd0", rd_data_a[31:0], 32'h2222);
    chk("prio_old_rd0", rd_data_b[31:0], 32'h0);
    chk("prio_rd1_r5", rd_data_a[63:32], 32'hDEADBEEF);

    // Different addresses on the two write ports, each read through a different port.
    we0 = 1'b1; waddr0 = 5'd21; wdata0 = 32'h0000_2121;
    we1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'h0000_2020; set_rd(5'd20, 5'd21);
    step();
    idle();
    chk("dual_byp_rd0_r20", rd_data_a[31:0], 32'h0000_2020);
    chk("dual_byp_rd1_r21", rd_data_a[63:32], 32'h0000_2121);
    step();
    chk("dual_old_rd1_r21", rd_data_b[63:32], 32'h0000_2121);

    // Register 0: writes and busy marks ignored only when hardwired to zero.
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    busy_set = 1'b1; busy_addr = 5'd0; set_rd(5'd0, 5'd0);
    step();
    idle();
    peek(5'd0);
    chk("z_rd0_a", rd_data_a[31:0], 32'h0);
    chk("z_dbg_a", dbg_data_a, 32'h0);
    chk("z_busy_a", busy_vec_a, 32'h0);
    chk("z_dbg_b", dbg_data_b, 32'hFFFFFFFF);
    chk("z_busy_b", busy_vec_b, 32'h0000_0001);
    step();
    chk("z_rd0_b", rd_data_b[31:0], 32'hFFFFFFFF);

    // Scoreboard set / set-vs-clear / clear.
    busy_set = 1'b1; busy_addr = 5'd9;
    step();
    chk("sb_set9", {31'h0, busy_vec_a[9]}, 32'h1);
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    step();
    idle();
    chk("sb_set_wins9", {31'h0, busy_vec_a[9]}, 32'h1);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h98;
    step();
    idle();
    chk("sb_clr9", {31'h0, busy_vec_a[9]}, 32'h0);

    // Two clears on different addresses plus an unrelated set in one edge.
    busy_set = 1'b1; busy_addr = 5'd11;
    step();
    busy_addr = 5'd12;
    step();
    idle();
    chk("sb_pre_a", busy_vec_a, 32'h0000_1800);
    we0 = 1'b1; waddr0 = 5'd11; wdata0 = 32'hB;
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'hC;
    busy_set = 1'b1; busy_addr = 5'd13;
    step();
    idle();
    chk("sb_multi_a", busy_vec_a, 32'h0000_2000);
    chk("sb_multi_b", busy_vec_b, 32'h0000_2001);

    // Mid-stream reset discards a concurrent write and busy mark.
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_A5A5;
    step();
    idle();
    busy_set = 1'b1; busy_addr = 5'd3;
    step();
    idle();
    peek(5'd3);
    chk("pre_rst_dbg_r3", dbg_data_a, 32'h0000_A5A5);
    chk("pre_rst_busy3", {31'h0, busy_vec_a[3]}, 32'h1);
    reset = 1'b1; we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h1234;
    busy_set = 1'b1; busy_addr = 5'd6; set_rd(5'd3, 5'd4);
    step();
    reset = 1'b0; idle();
    peek(5'd3);
    chk("mrst_dbg_r3", dbg_data_a, 32'h0);
    peek(5'd4);
    chk("mrst_dbg_r4", dbg_data_a, 32'h0);
    chk("mrst_dbg_b_r4", dbg_data_b, 32'h0);
    chk("mrst_busy_a", busy_vec_a, 32'h0);
    chk("mrst_busy_b", busy_vec_b, 32'h0);
    chk("mrst_rd0", rd_data_a[31:0], 32'h0);
    chk("mrst_rd1", rd_data_a[63:32], 32'h0);
    set_rd(5'd7, 5'd5);
    step();
    chk("post_rst_rd0_r7", rd_data_a[31:0], 32'h0);
    chk("post_rst_rd1_r5", rd_data_b[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the five-stage pipeline. Successor to the single-write, dual-read register file.
- Configurable width, depth and number of read ports; two write ports with fixed priority.
- Registered reads with optional same-cycle write-to-read bypass, plus an optional hardwired-zero register 0.
- A per-register busy scoreboard lets decode detect pending writebacks (RAW hazard) without external tracking.

Parameters:
- XLEN, 32, register data width in bits
- NREG, 32, number of architectural registers (power of two, >= 2)
- AW, 5, address width; must equal log2(NREG)
- NRP, 2, number of read ports (1..4)
- BYPASS, 1, 1 = write-first read (same-edge write visible on rd_data); 0 = read-old
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy

Ports:
- clk, input, 1, clock; all state updates on rising edge
- reset, input, 1, synchronous active-high reset
- rd_addr, input, NRP*AW, read addresses; port k occupies bits [k*AW +: AW]
- rd_data, output, NRP*XLEN, registered read data; port k occupies bits [k*XLEN +: XLEN]
- we0, input, 1, write enable, port 0
- waddr0, input, AW, write address, port 0
- wdata0, input, XLEN, write data, port 0
- we1, input, 1, write enable, port 1 (higher priority)
- waddr1, input, AW, write address, port 1
- wdata1, input, XLEN, write data, port 1
- busy_set, input, 1, mark busy_addr as having a pending write
- busy_addr, input, AW, register to mark busy
- busy_vec, output, NREG, registered scoreboard; bit i = register i pending
- dbg_addr, input, AW, debug/testbench read address
- dbg_data, output, XLEN, combinational read of array[dbg_addr]; no bypass

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset (reset=1 at an edge):
  - all NREG array entries <= 0, rd_data <= 0, busy_vec <= 0.
  - Writes, reads and busy_set presented in the same cycle are discarded.
  - Reset asserted mid-stream takes effect at that edge; state after deassertion is identical to power-up.
- Write:
  - At an edge, wePORT=1 writes wdataPORT to array[waddrPORT].
  - Both ports enabled to the same address: port 1 value stored, port 0 dropped.
  - Different addresses: both stored in the same edge.
  - ZERO_REG=1 and address 0: the write is ignored.
- Read (latency 1):
  - rd_data[k] after edge t reflects rd_addr[k] sampled at edge t.
  - BYPASS=1: returns post-write value at edge t. Same-address priority applies, so port 1 data wins over port 0.
  - BYPASS=0: returns array content before edge-t writes.
  - ZERO_REG=1, address 0: returns 0 regardless of bypass.
  - All read ports are independent; any number may alias the same address.
- Scoreboard:
  - busy_set=1 sets busy_vec[busy_addr] at the edge.
  - Any enabled write (either port) to address a clears busy_vec[a] at the edge.
  - Same edge set and clear of the same address: set wins (a new producer supersedes the completing one).
  - ZERO_REG=1: bit 0 is held 0.
  - Clears for different addresses from both write ports and one set apply together.
- dbg_data: purely combinational from the array. It shows the value after the most recent edge and ignores ZERO_REG masking only for index 0 when ZERO_REG=0.
- Widths:
  - No arithmetic; addresses are used unsigned.
  - NREG must equal 2**AW. Elaboration fails (generate-time check) otherwise, or if NRP is outside 1..4.
- No X propagation: array, rd_data and busy_vec are fully defined from the first reset.

Test Plan:
- Reset then read all registers via port 0 and port 1 with all write/busy inputs low -> every rd_data = 0, busy_vec = 0.
- we0=1, waddr0=5, wdata0=32'hDEADBEEF; same cycle rd_addr port0=5, BYPASS=1 -> next cycle rd_data port0 = DEADBEEF. With BYPASS=0 -> 0, then DEADBEEF one read later.
- we0=1 and we1=1 both to address 7, wdata0=32'h1111, wdata1=32'h2222 -> dbg_data at addr 7 = 2222; bypassed read returns 2222.
- ZERO_REG=1: write 32'hFFFFFFFF to address 0 and busy_set addr 0 -> rd_data = 0, dbg_data = 0, busy_vec[0] = 0.
- busy_set addr 9 -> busy_vec[9]=1. Next cycle busy_set addr 9 with we1 to addr 9 -> busy_vec[9] stays 1. Then we0 to addr 9 alone -> busy_vec[9]=0.
- Write 32'hA5A5 to addr 3, set busy addr 3, then assert reset for one cycle alongside we0 to addr 4 -> array[3]=0, array[4]=0, busy_vec=0, rd_data=0 after the edge.
